// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the multi-port RAM front end.
//   arb_state_t     : transaction state machine encoding
//   RAM_READ/WRITE  : values driven on ram_wr
//   DEFAULT_IO_BASE : first address of the non-pipelined IO window
//   decode_len()    : request length field -> byte count (0 means a full word)
package mem_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MEM_RD,
      DRAIN,
      MEM_WR,
      IO,
      DONE
   } arb_state_t;

   localparam logic RAM_READ  = 1'b0;
   localparam logic RAM_WRITE = 1'b1;

   localparam logic [31:0] DEFAULT_IO_BASE = 32'h0003_0000;

   // A zero length means a full word. Oversized lengths are clamped so
   // the byte index can never run past the client word.
   function automatic int unsigned decode_len(input int unsigned len,
                                              input int unsigned bytes);
      if (len == 0 || len > bytes) begin
         return bytes;
      end
      return len;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker
// Combinational round-robin priority encoder: returns the first set bit of
// cand at or after ptr, wrapping past the top index back to 0.
//   cand  in  N      candidate mask
//   ptr   in  PTR_W  highest-priority index this cycle
//   valid out 1      any candidate present
//   idx   out PTR_W  chosen index (0 when valid is low)
module rr_picker #(
   parameter int N     = 3,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     cand,
   input  logic [PTR_W-1:0] ptr,
   output logic             valid,
   output logic [PTR_W-1:0] idx
);

   // Two descending passes: the first leaves the lowest candidate below ptr,
   // the second overrides it with the lowest candidate at or above ptr.
   always_comb begin
      valid = |cand;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (cand[i] && i < int'(ptr)) begin
            idx = PTR_W'(i);
         end
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (cand[i] && i >= int'(ptr)) begin
            idx = PTR_W'(i);
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Multi-port front end to a byte-wide single-port RAM. Latches per-port
// requests, picks one round-robin (optionally writes first), then splits it
// into byte transactions: pipelined for normal memory, address+wait per byte
// for the IO window. Flush kills pending and in-flight reads of flushable ports.
//   clk, rst            clock, synchronous active-high reset
//   flush               rollback pulse
//   ram_din/ram_dout    RAM read data (valid the cycle after its address) / write data
//   ram_addr, ram_wr    RAM address and write strobe
//   req, req_wr         per-port request pulse and write flag
//   req_addr/len/wdata  flattened per-port request fields, port 0 in the low slice
//   ack                 one-cycle per-port completion pulse
//   rdata               zero-extended read result, valid while ack is high
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int                     NUM_PORTS   = 3,
   parameter int                     ADDR_WIDTH  = 32,
   parameter int                     DATA_WIDTH  = 32,
   parameter int                     LEN_W       = $clog2(DATA_WIDTH / 8) + 1,
   parameter logic [ADDR_WIDTH-1:0]  IO_BASE     = ADDR_WIDTH'(DEFAULT_IO_BASE),
   parameter int                     WRITE_FIRST = 1,
   parameter logic [NUM_PORTS-1:0]   FLUSHABLE   = NUM_PORTS'(3'b011)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            flush,
   input  logic [7:0]                      ram_din,
   output logic [7:0]                      ram_dout,
   output logic [ADDR_WIDTH-1:0]           ram_addr,
   output logic                            ram_wr,
   input  logic [NUM_PORTS-1:0]            req,
   input  logic [NUM_PORTS-1:0]            req_wr,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_PORTS*LEN_W-1:0]      req_len,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_PORTS-1:0]            ack,
   output logic [DATA_WIDTH-1:0]           rdata
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   // Per-port request latches
   logic [NUM_PORTS-1:0]  pending_reg;
   logic [NUM_PORTS-1:0]  pend_wr_reg;
   logic [ADDR_WIDTH-1:0] pend_addr_reg  [NUM_PORTS];
   logic [LEN_W-1:0]      pend_len_reg   [NUM_PORTS];
   logic [DATA_WIDTH-1:0] pend_wdata_reg [NUM_PORTS];

   // Arbitration
   logic [NUM_PORTS-1:0]  flush_mask, eligible, cand;
   logic [PTR_W-1:0]      rr_ptr_reg, pick_idx;
   logic                  pick_valid, grant;

   // Transaction in service
   arb_state_t            state_reg, state_next;
   logic [PTR_W-1:0]      cur_port_reg;
   logic                  cur_wr_reg;
   logic [ADDR_WIDTH-1:0] cur_addr_reg;
   logic [LEN_W-1:0]      cur_len_reg;
   logic [DATA_WIDTH-1:0] cur_wdata_reg;
   logic [LEN_W-1:0]      byte_cnt_reg, byte_cnt_next, next_idx;
   logic                  io_wait_reg, io_wait_next;
   logic                  cap_en, last_byte, abort;

   // Registered outputs
   logic [ADDR_WIDTH-1:0] ram_addr_reg, ram_addr_next;
   logic [7:0]            ram_dout_reg, ram_dout_next;
   logic                  ram_wr_reg, ram_wr_next;
   logic [NUM_PORTS-1:0]  ack_reg, ack_next;
   logic [DATA_WIDTH-1:0] rdata_reg;

   // Fields of the port the picker is pointing at
   logic [ADDR_WIDTH-1:0] g_addr;
   logic [LEN_W-1:0]      g_len;
   logic                  g_wr;

   assign flush_mask = flush ? FLUSHABLE : '0;
   assign eligible   = pending_reg & ~flush_mask;
   assign cand       = (WRITE_FIRST != 0 && |(eligible & pend_wr_reg))
                       ? (eligible & pend_wr_reg) : eligible;

   rr_picker #(.N(NUM_PORTS), .PTR_W(PTR_W)) u_picker (
      .cand  (cand),
      .ptr   (rr_ptr_reg),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign g_addr = pend_addr_reg[pick_idx];
   assign g_wr   = pend_wr_reg[pick_idx];
   assign g_len  = LEN_W'(decode_len(32'(pend_len_reg[pick_idx]), BYTES));

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         logic take;
         // A request coinciding with a flush of its port is dropped.
         assign take = req[gi] && !flush_mask[gi];

         // Capture beats the grant clear, so a re-request on the port being
         // granted stays queued behind the current transaction.
         always_ff @(posedge clk) begin
            if (rst) begin
               pending_reg[gi] <= 1'b0;
            end else if (take) begin
               pending_reg[gi] <= 1'b1;
            end else if (flush_mask[gi] || (grant && pick_idx == PTR_W'(gi))) begin
               pending_reg[gi] <= 1'b0;
            end
         end

         always_ff @(posedge clk) begin
            if (take) begin
               pend_wr_reg[gi]    <= req_wr[gi];
               pend_addr_reg[gi]  <= req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
               pend_len_reg[gi]   <= req_len[gi*LEN_W +: LEN_W];
               pend_wdata_reg[gi] <= req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end

      // Read bytes land in their own lane; the whole word is zeroed at grant
      // so short reads come back zero-extended.
      for (gi = 0; gi < BYTES; gi++) begin : g_rbyte
         always_ff @(posedge clk) begin
            if (rst || grant) begin
               rdata_reg[8*gi +: 8] <= 8'h00;
            end else if (cap_en && byte_cnt_reg == LEN_W'(gi)) begin
               rdata_reg[8*gi +: 8] <= ram_din;
            end
         end
      end
   endgenerate

   assign next_idx  = byte_cnt_reg + 1'b1;
   assign last_byte = (byte_cnt_reg == cur_len_reg - 1'b1);
   // Only reads of flushable ports are killed; writes always finish.
   assign abort     = flush && (state_reg != IDLE) && !cur_wr_reg && FLUSHABLE[cur_port_reg];

   always_comb begin
      state_next    = state_reg;
      ram_addr_next = ram_addr_reg;
      ram_dout_next = ram_dout_reg;
      ram_wr_next   = RAM_READ;
      byte_cnt_next = byte_cnt_reg;
      io_wait_next  = io_wait_reg;
      ack_next      = '0;
      cap_en        = 1'b0;
      grant         = 1'b0;

      case (state_reg)
         IDLE: begin
            if (pick_valid) begin
               grant         = 1'b1;
               ram_addr_next = g_addr;
               ram_dout_next = pend_wdata_reg[pick_idx][7:0];
               ram_wr_next   = g_wr ? RAM_WRITE : RAM_READ;
               byte_cnt_next = '0;
               io_wait_next  = 1'b0;
               if (g_addr >= IO_BASE) begin
                  state_next = IO;
               end else if (g_wr) begin
                  state_next = MEM_WR;
               end else if (g_len == LEN_W'(1)) begin
                  state_next = DRAIN;
               end else begin
                  state_next = MEM_RD;
               end
            end
         end
         MEM_RD: begin
            // Capture the byte for the address issued last cycle, issue the next.
            cap_en        = 1'b1;
            byte_cnt_next = next_idx;
            ram_addr_next = cur_addr_reg + ADDR_WIDTH'(next_idx);
            if (next_idx == cur_len_reg - 1'b1) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            cap_en     = 1'b1;
            state_next = DONE;
         end
         MEM_WR: begin
            if (last_byte) begin
               state_next = DONE;
            end else begin
               byte_cnt_next = next_idx;
               ram_addr_next = cur_addr_reg + ADDR_WIDTH'(next_idx);
               ram_dout_next = 8'(cur_wdata_reg >> (8 * next_idx));
               ram_wr_next   = RAM_WRITE;
            end
         end
         IO: begin
            if (!io_wait_reg) begin
               io_wait_next = 1'b1;
            end else begin
               cap_en = !cur_wr_reg;
               if (last_byte) begin
                  state_next = DONE;
               end else begin
                  byte_cnt_next = next_idx;
                  ram_addr_next = cur_addr_reg + ADDR_WIDTH'(next_idx);
                  ram_dout_next = 8'(cur_wdata_reg >> (8 * next_idx));
                  ram_wr_next   = cur_wr_reg ? RAM_WRITE : RAM_READ;
                  io_wait_next  = 1'b0;
               end
            end
         end
         DONE: begin
            ack_next[cur_port_reg] = 1'b1;
            state_next             = IDLE;
         end
         default: state_next = IDLE;
      endcase

      if (abort) begin
         state_next  = IDLE;
         ram_wr_next = RAM_READ;
         ack_next    = '0;
         cap_en      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         ram_addr_reg <= '0;
         ram_dout_reg <= '0;
         ram_wr_reg   <= RAM_READ;
         ack_reg      <= '0;
         byte_cnt_reg <= '0;
         io_wait_reg  <= 1'b0;
         rr_ptr_reg   <= '0;
      end else begin
         state_reg    <= state_next;
         ram_addr_reg <= ram_addr_next;
         ram_dout_reg <= ram_dout_next;
         ram_wr_reg   <= ram_wr_next;
         ack_reg      <= ack_next;
         byte_cnt_reg <= byte_cnt_next;
         io_wait_reg  <= io_wait_next;
         if (grant) begin
            rr_ptr_reg <= (pick_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : pick_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (grant) begin
         cur_port_reg  <= pick_idx;
         cur_wr_reg    <= g_wr;
         cur_addr_reg  <= g_addr;
         cur_len_reg   <= g_len;
         cur_wdata_reg <= pend_wdata_reg[pick_idx];
      end
   end

   assign ram_addr = ram_addr_reg;
   assign ram_dout = ram_dout_reg;
   assign ram_wr   = ram_wr_reg;
   assign ack      = ack_reg;
   assign rdata    = rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a byte RAM model and a scoreboard
// of expected completions (port, read data, completion edge).
module tb_mem_port_arbiter;

   localparam int NP = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 3;

   logic              clk = 1'b0;
   logic              rst, flush;
   logic [7:0]        ram_din, ram_dout;
   logic [AW-1:0]     ram_addr;
   logic              ram_wr;
   logic [NP-1:0]     req, req_wr, ack;
   logic [NP*AW-1:0]  req_addr;
   logic [NP*LW-1:0]  req_len;
   logic [NP*DW-1:0]  req_wdata;
   logic [DW-1:0]     rdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .NUM_PORTS   (NP),
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .LEN_W       (LW),
      .IO_BASE     (32'h0003_0000),
      .WRITE_FIRST (1),
      .FLUSHABLE   (3'b011)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout),
      .ram_addr  (ram_addr),
      .ram_wr    (ram_wr),
      .req       (req),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .req_wdata (req_wdata),
      .ack       (ack),
      .rdata     (rdata)
   );

   // RAM model: read data follows the address presented on the bus
   logic [7:0] mem [4096];
   logic       loaded = 1'b0;
   assign ram_din = mem[ram_addr[11:0]];

   always @(posedge clk) begin
      if (!loaded) begin
         loaded <= 1'b1;
         mem[12'h100] <= 8'h11; mem[12'h101] <= 8'h22;
         mem[12'h102] <= 8'h33; mem[12'h103] <= 8'h44;
         mem[12'h200] <= 8'h55; mem[12'h201] <= 8'h66;
         mem[12'h300] <= 8'h0A; mem[12'h301] <= 8'h0B;
         mem[12'h302] <= 8'h0C; mem[12'h303] <= 8'h0D;
         mem[12'h400] <= 8'h77; mem[12'h401] <= 8'h88;
         mem[12'h602] <= 8'h00; mem[12'h603] <= 8'h00;
      end
      if (ram_wr) mem[ram_addr[11:0]] <= ram_dout;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int          port;
      logic [31:0] data;
      bit          chk_data;
      int          at;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int p, input bit wr, input logic [31:0] addr,
                          input int len, input logic [31:0] wd);
      req[p]               = 1'b1;
      req_wr[p]            = wr;
      req_addr[p*AW +: AW] = addr;
      req_len[p*LW +: LW]  = LW'(len);
      req_wdata[p*DW +: DW] = wd;
   endtask

   task automatic wait_drain(input int max, input string tag);
      for (int i = 0; i < max && sb.size() != 0; i++) step();
      check({tag, "_drain"}, 64'(sb.size()), 64'd0);
      repeat (3) step();
   endtask

   // Completion monitor: every ack must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && ack != '0) begin
         if (sb.size() == 0) begin
            check("unexpected_ack", 64'(ack), 64'd0);
         end else begin
            mon_e = sb.pop_front();
            $display("ack port %0d at edge %0d rdata %08h", mon_e.port, cyc, rdata);
            check("ack_port", 64'(ack), 64'(NP'(1) << mon_e.port));
            if (mon_e.chk_data) check("rdata", 64'(rdata), 64'(mon_e.data));
            if (mon_e.at >= 0) check("ack_edge", 64'(cyc), 64'(mon_e.at));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      rst = 1'b1; flush = 1'b0;
      req = '0; req_wr = '0; req_addr = '0; req_len = '0; req_wdata = '0;
      repeat (3) step();
      rst = 1'b0;
      step();
      check("rst_addr",  64'(ram_addr), 64'd0);
      check("rst_dout",  64'(ram_dout), 64'd0);
      check("rst_wr",    64'(ram_wr),   64'd0);
      check("rst_ack",   64'(ack),      64'd0);
      check("rst_rdata", 64'(rdata),    64'd0);

      // 1: port 1 reads 4 bytes at 0x100, ack at R+6
      set_req(1, 1'b0, 32'h100, 4, 32'h0);
      r = cyc + 1;
      sb.push_back('{1, 32'h4433_2211, 1'b1, r + 6});
      step(); req = '0;
      for (int k = 0; k < 4; k++) begin
         step();
         check("t1_addr", 64'(ram_addr), 64'(32'h100 + k));
         check("t1_rd",   64'(ram_wr),   64'd0);
      end
      wait_drain(20, "t1");

      // 2: two reads and an IO write together; the write goes first
      set_req(0, 1'b0, 32'h200, 2, 32'h0);
      set_req(1, 1'b0, 32'h300, 0, 32'h0);
      set_req(2, 1'b1, 32'h3_0000, 1, 32'hAB);
      r = cyc + 1;
      sb.push_back('{2, 32'h0, 1'b0, r + 4});
      sb.push_back('{0, 32'h0000_6655, 1'b1, r + 8});
      sb.push_back('{1, 32'h0D0C_0B0A, 1'b1, r + 14});
      step(); req = '0;
      step();
      check("t2_io_addr", 64'(ram_addr), 64'h3_0000);
      check("t2_io_wr",   64'(ram_wr),   64'd1);
      check("t2_io_dout", 64'(ram_dout), 64'hAB);
      step();
      check("t2_io_wait", 64'(ram_wr),   64'd0);
      wait_drain(40, "t2");

      // 3: ports 0 and 1 request continuously; grants alternate 0,1,0,1,...
      r = cyc + 1;
      for (int k = 0; k < 6; k++)
         sb.push_back('{k % 2, (k % 2 != 0) ? 32'h88 : 32'h77, 1'b1, r + 3 + 3 * k});
      for (int i = 0; i < 12; i++) begin
         set_req(0, 1'b0, 32'h400, 1, 32'h0);
         set_req(1, 1'b0, 32'h401, 1, 32'h0);
         step();
      end
      req = '0;
      wait_drain(40, "t3");

      // 4: flush two cycles into a port 0 read; port 2 served instead
      set_req(0, 1'b0, 32'h100, 4, 32'h0);
      step(); req = '0;
      set_req(2, 1'b0, 32'h200, 2, 32'h0);
      sb.push_back('{2, 32'h0000_6655, 1'b1, -1});
      step(); req = '0;
      step();
      flush = 1'b1;
      step(); flush = 1'b0;
      check("t4_abort_wr", 64'(ram_wr), 64'd0);
      wait_drain(30, "t4");

      // 5: flush during a port 0 write; write completes, port 1 read dropped,
      //    port 0 re-request dropped, port 2 request captured
      set_req(0, 1'b1, 32'h500, 4, 32'hDEAD_BEEF);
      set_req(1, 1'b0, 32'h100, 4, 32'h0);
      r = cyc + 1;
      sb.push_back('{0, 32'h0, 1'b0, r + 6});
      step(); req = '0;
      step();
      check("t5_wr0",   64'(ram_wr),   64'd1);
      check("t5_dout0", 64'(ram_dout), 64'hEF);
      set_req(0, 1'b0, 32'h100, 4, 32'h0);
      set_req(2, 1'b0, 32'h401, 1, 32'h0);
      flush = 1'b1;
      step(); req = '0; flush = 1'b0;
      sb.push_back('{2, 32'h88, 1'b1, -1});
      check("t5_wr1",   64'(ram_wr),   64'd1);
      check("t5_addr1", 64'(ram_addr), 64'h501);
      check("t5_dout1", 64'(ram_dout), 64'hBE);
      wait_drain(40, "t5");
      check("t5_mem", 64'({mem[12'h503], mem[12'h502], mem[12'h501], mem[12'h500]}),
            64'hDEAD_BEEF);

      // 6: reset in the middle of a write with a read pending
      set_req(0, 1'b1, 32'h600, 4, 32'h1122_3344);
      step(); req = '0;
      set_req(1, 1'b0, 32'h100, 4, 32'h0);
      step(); req = '0;
      check("t6_wr", 64'(ram_wr), 64'd1);
      step();
      rst = 1'b1;
      step(); rst = 1'b0;
      check("t6_rst_wr",   64'(ram_wr),   64'd0);
      check("t6_rst_ack",  64'(ack),      64'd0);
      check("t6_rst_addr", 64'(ram_addr), 64'd0);
      repeat (12) step();
      check("t6_mem", 64'({mem[12'h603], mem[12'h602]}), 64'h0);
      check("t6_quiet_wr", 64'(ram_wr), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
